// File: rtl/dma_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : dma_controller_if
// Description : System-bus signal bundle between the DMA bus master and the
//               shared bus (slave side / arbiter).
// Revision    : 1.0 - initial release
// ============================================================================
interface dma_controller_if;
  logic [31:0] address_dataIN;
  logic        end_transactionIN;
  logic        data_validIN;
  logic        busyIN;
  logic        bus_errorIN;
  logic        transactionGranted;
  logic [31:0] address_dataOUT;
  logic [3:0]  byte_enableOUT;
  logic [7:0]  burst_sizeOUT;
  logic        read_n_writeOUT;
  logic        begin_transactionOUT;
  logic        end_transactionOUT;
  logic        data_validOUT;
  logic        busyOUT;
  logic        requestTransaction;

  modport master (
    input  address_dataIN, end_transactionIN, data_validIN, busyIN,
           bus_errorIN, transactionGranted,
    output address_dataOUT, byte_enableOUT, burst_sizeOUT, read_n_writeOUT,
           begin_transactionOUT, end_transactionOUT, data_validOUT, busyOUT,
           requestTransaction
  );

  modport slave (
    output address_dataIN, end_transactionIN, data_validIN, busyIN,
           bus_errorIN, transactionGranted,
    input  address_dataOUT, byte_enableOUT, burst_sizeOUT, read_n_writeOUT,
           begin_transactionOUT, end_transactionOUT, data_validOUT, busyOUT,
           requestTransaction
  );
endinterface
`default_nettype wire

// File: rtl/dma_controller.sv
`default_nettype none
// ============================================================================
// Module      : dma_controller
// Description : Bus-master DMA engine moving blocks of 32-bit words between a
//               512-word ping-pong buffer and the system bus, split into
//               arbitrated bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_controller (
  input  wire logic        clock,
  input  wire logic        n_reset,
  input  wire logic        ipcore_launch_write,
  input  wire logic        ipcore_launch_read,
  input  wire logic [3:0]  ipcore_byte_enable,
  input  wire logic [31:0] ipcore_address,
  input  wire logic [7:0]  ipcore_burst_size,
  input  wire logic [7:0]  ipcore_block_sizeIN,
  output logic             ipcore_dma_busy,
  output logic [7:0]       ipcore_block_sizeOUT,
  output logic [8:0]       pp_address,
  output logic [31:0]      pp_dataIn,
  output logic             pp_writeEnable,
  input  wire logic [31:0] pp_dataOut,
  output logic [3:0]       s_dma_cur_state,
  dma_controller_if.master bus
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_REQUEST   = 4'd1,
    ST_BEGIN     = 4'd2,
    ST_WRITE     = 4'd3,
    ST_END_WRITE = 4'd4,
    ST_READ      = 4'd5,
    ST_NEXT      = 4'd6,
    ST_ERROR     = 4'd7
  } state_t;

  state_t      r_state;

  // Block parameters latched at launch
  logic [31:0] r_start_addr;
  logic [3:0]  r_be;
  logic [7:0]  r_burst;       // already clamped to a minimum of 1
  logic [7:0]  r_block;
  logic        r_read;

  // Progress counters
  logic [7:0]  r_words;       // words completed in this block
  logic [7:0]  r_beats_left;  // beats still to send in current write burst

  // Registered bus / status outputs
  logic        r_busy;
  logic        r_req;
  logic        r_begin;
  logic        r_end;
  logic        r_dvalid;
  logic        r_rnw;
  logic [3:0]  r_be_out;
  logic [7:0]  r_bsize;
  logic [31:0] r_addr_out;

  logic [7:0]  w_remaining;
  logic [7:0]  w_beats;
  logic [31:0] w_begin_addr;
  logic        w_launch;
  logic        w_bus_error;
  logic        w_rd_beat;
  logic [8:0]  w_pp_address;

  assign w_remaining  = r_block - r_words;
  assign w_beats      = (r_burst < w_remaining) ? r_burst : w_remaining;
  assign w_begin_addr = r_start_addr + {22'd0, r_words, 2'b00};
  assign w_launch     = (ipcore_launch_write | ipcore_launch_read) &&
                        (ipcore_block_sizeIN != 8'd0);
  // IDLE cannot abort and ERROR is already on its way back to IDLE
  assign w_bus_error  = bus.bus_errorIN && (r_state != ST_IDLE) &&
                        (r_state != ST_ERROR);
  assign w_rd_beat    = (r_state == ST_READ) && bus.data_validIN &&
                        !bus.bus_errorIN;

  // Buffer index: the buffer has one cycle of read latency, so while writing
  // the index looks one word ahead whenever the current beat is accepted and
  // stays on the current word while the slave stalls.
  always_comb begin
    w_pp_address = 9'd0;
    case (r_state)
      ST_BEGIN: if (!r_read) w_pp_address = {1'b0, r_words};
      ST_WRITE: w_pp_address = {1'b0, r_words} + {8'd0, ~bus.busyIN};
      ST_READ:  w_pp_address = {1'b0, r_words};
      default:  w_pp_address = 9'd0;
    endcase
  end

  // Main transfer FSM with registered outputs and per-block bookkeeping
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state      <= ST_IDLE;
      r_start_addr <= 32'd0;
      r_be         <= 4'd0;
      r_burst      <= 8'd0;
      r_block      <= 8'd0;
      r_read       <= 1'b0;
      r_words      <= 8'd0;
      r_beats_left <= 8'd0;
      r_busy       <= 1'b0;
      r_req        <= 1'b0;
      r_begin      <= 1'b0;
      r_end        <= 1'b0;
      r_dvalid     <= 1'b0;
      r_rnw        <= 1'b0;
      r_be_out     <= 4'd0;
      r_bsize      <= 8'd0;
      r_addr_out   <= 32'd0;
    end else if (w_bus_error) begin
      // Abort: silence the bus but keep the word count for software
      r_state    <= ST_ERROR;
      r_req      <= 1'b0;
      r_begin    <= 1'b0;
      r_end      <= 1'b0;
      r_dvalid   <= 1'b0;
      r_rnw      <= 1'b0;
      r_be_out   <= 4'd0;
      r_bsize    <= 8'd0;
      r_addr_out <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_start_addr <= ipcore_address;
            r_be         <= ipcore_byte_enable;
            r_burst      <= (ipcore_burst_size == 8'd0) ? 8'd1 : ipcore_burst_size;
            r_block      <= ipcore_block_sizeIN;
            r_read       <= !ipcore_launch_write;
            r_words      <= 8'd0;
            r_busy       <= 1'b1;
            r_req        <= 1'b1;
            r_state      <= ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          if (bus.transactionGranted) begin
            r_state      <= ST_BEGIN;
            r_begin      <= 1'b1;
            r_addr_out   <= w_begin_addr;
            r_bsize      <= w_beats - 8'd1;
            r_be_out     <= r_be;
            r_rnw        <= r_read;
            r_beats_left <= w_beats;
          end
        end
        ST_BEGIN: begin
          r_begin    <= 1'b0;
          r_addr_out <= 32'd0;
          r_bsize    <= 8'd0;
          if (r_read) begin
            r_state <= ST_READ;
          end else begin
            r_state  <= ST_WRITE;
            r_dvalid <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (!bus.busyIN) begin
            r_words <= r_words + 8'd1;
            if (r_beats_left == 8'd1) begin
              r_state  <= ST_END_WRITE;
              r_dvalid <= 1'b0;
              r_end    <= 1'b1;
              r_req    <= 1'b0;
              r_be_out <= 4'd0;
            end else begin
              r_beats_left <= r_beats_left - 8'd1;
            end
          end
        end
        ST_END_WRITE: begin
          r_end   <= 1'b0;
          r_state <= ST_NEXT;
        end
        ST_READ: begin
          if (bus.data_validIN) r_words <= r_words + 8'd1;
          if (bus.end_transactionIN) begin
            r_state  <= ST_NEXT;
            r_req    <= 1'b0;
            r_rnw    <= 1'b0;
            r_be_out <= 4'd0;
          end
        end
        ST_NEXT: begin
          if (r_words == r_block) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            // Every burst re-arbitrates for the bus
            r_state <= ST_REQUEST;
            r_req   <= 1'b1;
          end
        end
        ST_ERROR: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ipcore_dma_busy      = r_busy;
  assign ipcore_block_sizeOUT = r_words;
  assign s_dma_cur_state      = r_state;

  assign pp_address     = w_pp_address;
  assign pp_writeEnable = w_rd_beat;
  assign pp_dataIn      = w_rd_beat ? bus.address_dataIN : 32'd0;

  // Write beats carry buffer data straight from the buffer read port
  assign bus.address_dataOUT      = (r_state == ST_WRITE) ? pp_dataOut : r_addr_out;
  assign bus.byte_enableOUT       = r_be_out;
  assign bus.burst_sizeOUT        = r_bsize;
  assign bus.read_n_writeOUT      = r_rnw;
  assign bus.begin_transactionOUT = r_begin;
  assign bus.end_transactionOUT   = r_end;
  assign bus.data_validOUT        = r_dvalid;
  assign bus.busyOUT              = 1'b0;
  assign bus.requestTransaction   = r_req;

endmodule
`default_nettype wire

// File: tb/tb_dma_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_controller
// Description : Directed self-checking bench for dma_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_controller;

  logic        clock;
  logic        n_reset;
  logic        ipcore_launch_write;
  logic        ipcore_launch_read;
  logic [3:0]  ipcore_byte_enable;
  logic [31:0] ipcore_address;
  logic [7:0]  ipcore_burst_size;
  logic [7:0]  ipcore_block_sizeIN;
  logic        ipcore_dma_busy;
  logic [7:0]  ipcore_block_sizeOUT;
  logic [8:0]  pp_address;
  logic [31:0] pp_dataIn;
  logic        pp_writeEnable;
  logic [31:0] pp_dataOut;
  logic [3:0]  s_dma_cur_state;

  dma_controller_if bus ();

  dma_controller dut (
    .clock                (clock),
    .n_reset              (n_reset),
    .ipcore_launch_write  (ipcore_launch_write),
    .ipcore_launch_read   (ipcore_launch_read),
    .ipcore_byte_enable   (ipcore_byte_enable),
    .ipcore_address       (ipcore_address),
    .ipcore_burst_size    (ipcore_burst_size),
    .ipcore_block_sizeIN  (ipcore_block_sizeIN),
    .ipcore_dma_busy      (ipcore_dma_busy),
    .ipcore_block_sizeOUT (ipcore_block_sizeOUT),
    .pp_address           (pp_address),
    .pp_dataIn            (pp_dataIn),
    .pp_writeEnable       (pp_writeEnable),
    .pp_dataOut           (pp_dataOut),
    .s_dma_cur_state      (s_dma_cur_state),
    .bus                  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Buffer contents are a fixed function of the index
  function automatic logic [31:0] src_word(input logic [8:0] a);
    return {16'hC0DE, 7'd0, a};
  endfunction

  // Ping-pong buffer read port, one cycle latency
  always @(posedge clock) pp_dataOut <= src_word(pp_address);

  // Bus / buffer monitors
  logic [31:0] beat_data [1024];
  logic [31:0] beg_addr  [256];
  logic [7:0]  beg_bs    [256];
  logic        beg_rnw   [256];
  logic [8:0]  we_idx    [256];
  logic [31:0] we_data   [256];
  int beat_cnt = 0, beg_cnt = 0, end_cnt = 0, we_cnt = 0;
  int stall_cnt = 0, freeze_err = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = 32'd0;

  always @(negedge clock) begin
    if (bus.data_validOUT && !bus.busyIN && !bus.bus_errorIN) begin
      beat_data[beat_cnt] <= bus.address_dataOUT;
      beat_cnt <= beat_cnt + 1;
    end
    if (bus.begin_transactionOUT) begin
      beg_addr[beg_cnt] <= bus.address_dataOUT;
      beg_bs[beg_cnt]   <= bus.burst_sizeOUT;
      beg_rnw[beg_cnt]  <= bus.read_n_writeOUT;
      beg_cnt <= beg_cnt + 1;
    end
    if (bus.end_transactionOUT) end_cnt <= end_cnt + 1;
    if (pp_writeEnable) begin
      we_idx[we_cnt]  <= pp_address;
      we_data[we_cnt] <= pp_dataIn;
      we_cnt <= we_cnt + 1;
    end
    if (bus.data_validOUT && bus.busyIN) stall_cnt <= stall_cnt + 1;
    if (prev_stall && !(bus.data_validOUT && bus.address_dataOUT == prev_data))
      freeze_err <= freeze_err + 1;
    prev_stall <= bus.data_validOUT && bus.busyIN;
    prev_data  <= bus.address_dataOUT;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic sample();
    @(negedge clock); #1;
  endtask

  task automatic launch(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [7:0] burst, input logic [7:0] blk);
    step();
    ipcore_launch_write = wr;
    ipcore_launch_read  = rd;
    ipcore_address      = addr;
    ipcore_byte_enable  = 4'hF;
    ipcore_burst_size   = burst;
    ipcore_block_sizeIN = blk;
    step();
    ipcore_launch_write = 1'b0;
    ipcore_launch_read  = 1'b0;
  endtask

  task automatic wait_begin(input int target);
    for (int i = 0; i < 300; i++) begin
      if (beg_cnt >= target) break;
      sample();
    end
    check("begin_timeout", 32'(beg_cnt >= target), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      sample();
      if (!ipcore_dma_busy) break;
    end
    check("idle_timeout", 32'(ipcore_dma_busy), 32'd0);
  endtask

  // Compares n captured write beats from base against buffer words 0..n-1
  task automatic check_beats(input string tag, input int base, input int n);
    int nbad;
    nbad = 0;
    for (int i = 0; i < n; i++)
      if (beat_data[base + i] !== src_word(9'(i))) nbad++;
    check(tag, 32'(nbad), 32'd0);
  endtask

  int b0, g0, e0, w0, s0;

  initial begin
    n_reset = 1'b0;
    ipcore_launch_write = 1'b0;
    ipcore_launch_read  = 1'b0;
    ipcore_byte_enable  = 4'h0;
    ipcore_address      = 32'd0;
    ipcore_burst_size   = 8'd0;
    ipcore_block_sizeIN = 8'd0;
    bus.address_dataIN     = 32'd0;
    bus.end_transactionIN  = 1'b0;
    bus.data_validIN       = 1'b0;
    bus.busyIN             = 1'b0;
    bus.bus_errorIN        = 1'b0;
    bus.transactionGranted = 1'b1;

    // Reset state
    repeat (2) step();
    sample();
    check("rst_state", 32'(s_dma_cur_state), 32'd0);
    check("rst_busy", 32'(ipcore_dma_busy), 32'd0);
    check("rst_req", 32'(bus.requestTransaction), 32'd0);
    check("rst_addr_data", bus.address_dataOUT, 32'd0);
    check("rst_count", 32'(ipcore_block_sizeOUT), 32'd0);
    step();
    n_reset = 1'b1;

    // Block size 0 does nothing
    launch(1'b1, 1'b0, 32'h1234_0000, 8'd4, 8'd0);
    sample();
    check("blk0_busy", 32'(ipcore_dma_busy), 32'd0);
    check("blk0_state", 32'(s_dma_cur_state), 32'd0);

    // Write 19 words, bursts of 10
    b0 = beat_cnt; g0 = beg_cnt; e0 = end_cnt;
    launch(1'b1, 1'b0, 32'hAABB_CCDD, 8'd10, 8'd19);
    wait_idle();
    check("wr_begins", 32'(beg_cnt - g0), 32'd2);
    check("wr_addr0", beg_addr[g0], 32'hAABB_CCDD);
    check("wr_bs0", 32'(beg_bs[g0]), 32'd9);
    check("wr_addr1", beg_addr[g0 + 1], 32'hAABB_CCDD + 32'd40);
    check("wr_bs1", 32'(beg_bs[g0 + 1]), 32'd8);
    check("wr_rnw", 32'(beg_rnw[g0]), 32'd0);
    check("wr_beats", 32'(beat_cnt - b0), 32'd19);
    check_beats("wr_data", b0, 19);
    check("wr_ends", 32'(end_cnt - e0), 32'd2);
    check("wr_count", 32'(ipcore_block_sizeOUT), 32'd19);

    // Same write with a 10-cycle slave stall inside the first burst
    b0 = beat_cnt; g0 = beg_cnt; s0 = stall_cnt;
    launch(1'b1, 1'b0, 32'hAABB_CCDD, 8'd10, 8'd19);
    wait_begin(g0 + 1);
    step();
    repeat (3) step();
    bus.busyIN = 1'b1;
    repeat (10) step();
    bus.busyIN = 1'b0;
    wait_idle();
    check("stall_cycles", 32'(stall_cnt - s0), 32'd10);
    check("stall_freeze", 32'(freeze_err), 32'd0);
    check("stall_beats", 32'(beat_cnt - b0), 32'd19);
    check_beats("stall_data", b0, 19);
    check("stall_count", 32'(ipcore_block_sizeOUT), 32'd19);

    // Grant withheld, then dropped between bursts
    b0 = beat_cnt; g0 = beg_cnt; e0 = end_cnt;
    bus.transactionGranted = 1'b0;
    launch(1'b1, 1'b0, 32'h0000_0100, 8'd2, 8'd5);
    repeat (6) sample();
    check("gnt_wait_state", 32'(s_dma_cur_state), 32'd1);
    check("gnt_wait_req", 32'(bus.requestTransaction), 32'd1);
    check("gnt_wait_begins", 32'(beg_cnt - g0), 32'd0);
    bus.transactionGranted = 1'b1;
    wait_begin(g0 + 1);
    bus.transactionGranted = 1'b0;
    repeat (8) sample();
    check("gnt_gap_begins", 32'(beg_cnt - g0), 32'd1);
    check("gnt_gap_state", 32'(s_dma_cur_state), 32'd1);
    check("gnt_gap_req", 32'(bus.requestTransaction), 32'd1);
    check("gnt_gap_beats", 32'(beat_cnt - b0), 32'd2);
    bus.transactionGranted = 1'b1;
    wait_idle();
    check("gnt_begins", 32'(beg_cnt - g0), 32'd3);
    check("gnt_addr2", beg_addr[g0 + 2], 32'h0000_0110);
    check("gnt_bs2", 32'(beg_bs[g0 + 2]), 32'd0);
    check("gnt_beats", 32'(beat_cnt - b0), 32'd5);
    check_beats("gnt_data", b0, 5);

    // Burst size 0 behaves as single-beat bursts
    g0 = beg_cnt;
    launch(1'b1, 1'b0, 32'h0000_0040, 8'd0, 8'd2);
    wait_idle();
    check("b0_begins", 32'(beg_cnt - g0), 32'd2);
    check("b0_bs", 32'(beg_bs[g0 + 1]), 32'd0);
    check("b0_addr1", beg_addr[g0 + 1], 32'h0000_0044);

    // Read 20 words in bursts of 10
    g0 = beg_cnt; w0 = we_cnt;
    launch(1'b0, 1'b1, 32'h00F0_0000, 8'd10, 8'd20);
    for (int b = 0; b < 2; b++) begin
      wait_begin(g0 + b + 1);
      step();
      for (int k = 0; k < 10; k++) begin
        bus.data_validIN   = 1'b1;
        bus.address_dataIN = 32'hA000_0000 + 32'(b * 10 + k);
        step();
      end
      bus.data_validIN      = 1'b0;
      bus.end_transactionIN = 1'b1;
      step();
      bus.end_transactionIN = 1'b0;
    end
    wait_idle();
    check("rd_we_count", 32'(we_cnt - w0), 32'd20);
    begin
      int nbad;
      nbad = 0;
      for (int i = 0; i < 20; i++)
        if (we_idx[w0 + i] !== 9'(i) || we_data[w0 + i] !== 32'hA000_0000 + 32'(i))
          nbad++;
      check("rd_we_data", 32'(nbad), 32'd0);
    end
    check("rd_rnw0", 32'(beg_rnw[g0]), 32'd1);
    check("rd_rnw1", 32'(beg_rnw[g0 + 1]), 32'd1);
    check("rd_addr1", beg_addr[g0 + 1], 32'h00F0_0028);
    check("rd_bs1", 32'(beg_bs[g0 + 1]), 32'd9);
    check("rd_count", 32'(ipcore_block_sizeOUT), 32'd20);

    // Bus error in the middle of a 200-word write
    b0 = beat_cnt; g0 = beg_cnt;
    launch(1'b1, 1'b0, 32'h0001_0000, 8'd16, 8'd200);
    wait_begin(g0 + 3);
    step();
    repeat (5) step();
    bus.bus_errorIN = 1'b1;
    step();
    bus.bus_errorIN = 1'b0;
    sample();
    check("err_state", 32'(s_dma_cur_state), 32'd7);
    check("err_req", 32'(bus.requestTransaction), 32'd0);
    check("err_valid", 32'(bus.data_validOUT), 32'd0);
    sample();
    check("err_idle", 32'(s_dma_cur_state), 32'd0);
    check("err_busy", 32'(ipcore_dma_busy), 32'd0);
    check("err_count", 32'(ipcore_block_sizeOUT), 32'd37);
    check("err_beats", 32'(beat_cnt - b0), 32'd37);

    // Asynchronous reset mid-burst, then a fresh transfer
    g0 = beg_cnt;
    launch(1'b1, 1'b0, 32'hAABB_CCDD, 8'd10, 8'd19);
    wait_begin(g0 + 1);
    step();
    repeat (3) step();
    n_reset = 1'b0;
    #2;
    check("rstm_state", 32'(s_dma_cur_state), 32'd0);
    check("rstm_busy", 32'(ipcore_dma_busy), 32'd0);
    check("rstm_valid", 32'(bus.data_validOUT), 32'd0);
    check("rstm_req", 32'(bus.requestTransaction), 32'd0);
    check("rstm_count", 32'(ipcore_block_sizeOUT), 32'd0);
    step();
    n_reset = 1'b1;
    b0 = beat_cnt; g0 = beg_cnt;
    launch(1'b1, 1'b0, 32'h0000_2000, 8'd4, 8'd3);
    wait_idle();
    check("post_begins", 32'(beg_cnt - g0), 32'd1);
    check("post_bs", 32'(beg_bs[g0]), 32'd2);
    check("post_addr", beg_addr[g0], 32'h0000_2000);
    check_beats("post_data", b0, 3);
    check("post_count", 32'(ipcore_block_sizeOUT), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
